// File: rtl/dmem_pkg.sv
// Shared definitions for the two-port data-memory arbiter: FSM states,
// port count and default bus widths.
package dmem_pkg;

  localparam int NPORT  = 2;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer to the
// last granted port advanced only when the caller commits to the grant.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NPORT-1:0] req,
  input  logic             advance,
  output logic [NPORT-1:0] gnt
);

  // last = 1 means port 1 was granted most recently, so port 0 wins a tie
  logic last;

  always_comb begin
    gnt = req;
    if (&req) gnt = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last <= 1'b1;
    else if (advance && |gnt)  last <= gnt[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between CPU (port 0) and loader/DMA (port 1).
// Each access runs IDLE -> ACCESS -> DONE, one cycle per state.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_done,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_done,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_add,
  output logic [DW-1:0] mem_data_in,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_data_out
);

  state_e           state, state_nxt;
  logic [NPORT-1:0] req, win;
  logic             take, owner, we_q;

  // Valid/ready: a port holds req with stable fields until its gnt pulse;
  // fields are latched on the edge that enters ACCESS, so req may drop
  // from the gnt cycle onwards. done marks completion, rdata valid with it.
  assign req  = {p1_req, p0_req};
  assign take = (state == IDLE) && (|req);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (take),
    .gnt     (win)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    p0_done   = 1'b0;
    p1_done   = 1'b0;
    case (state)
      IDLE:    if (|req) state_nxt = ACCESS;
      ACCESS: begin
        state_nxt = DONE;
        p0_gnt    = ~owner;
        p1_gnt    = owner;
      end
      DONE: begin
        state_nxt = IDLE;
        p0_done   = ~owner;
        p1_done   = owner;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_wr is set only on entry to ACCESS, so it is high for that one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner       <= 1'b0;
      we_q        <= 1'b0;
      mem_add     <= '0;
      mem_data_in <= '0;
      mem_wr      <= 1'b0;
      rdata       <= '0;
    end else begin
      mem_wr <= 1'b0;
      if (take) begin
        owner       <= win[1];
        we_q        <= win[1] ? p1_we    : p0_we;
        mem_add     <= win[1] ? p1_addr  : p0_addr;
        mem_data_in <= win[1] ? p1_wdata : p0_wdata;
        mem_wr      <= win[1] ? p1_we    : p0_we;
      end
      if (state == ACCESS && !we_q) rdata <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus hand-written
// reset-abort and post-reset tie sequences against a small memory model.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [7:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic       p0_gnt, p0_done, p1_gnt, p1_done, mem_wr;
  logic [7:0] rdata, mem_add, mem_data_in, mem_data_out;

  logic [7:0] mem [256];
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic       r0, w0;
    logic [7:0] a0, d0;
    logic       r1, w1;
    logic [7:0] a1, d1;
    logic [3:0] pul;   // {p0_gnt, p1_gnt, p0_done, p1_done}
    logic       wr;
    logic [7:0] add, din, rd;
  } vec_t;

  vec_t vecs [30];

  dmem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_req       (p0_req),
    .p0_we        (p0_we),
    .p0_addr      (p0_addr),
    .p0_wdata     (p0_wdata),
    .p0_gnt       (p0_gnt),
    .p0_done      (p0_done),
    .p1_req       (p1_req),
    .p1_we        (p1_we),
    .p1_addr      (p1_addr),
    .p1_wdata     (p1_wdata),
    .p1_gnt       (p1_gnt),
    .p1_done      (p1_done),
    .rdata        (rdata),
    .mem_add      (mem_add),
    .mem_data_in  (mem_data_in),
    .mem_wr       (mem_wr),
    .mem_data_out (mem_data_out)
  );

  // clock / memory model
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_wr) mem[mem_add] <= mem_data_in;
  assign mem_data_out = mem[mem_add];

  function automatic vec_t mk(input logic r0, w0, input logic [7:0] a0, d0,
                              input logic r1, w1, input logic [7:0] a1, d1,
                              input logic [3:0] pul, input logic wr,
                              input logic [7:0] add, din, rd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.pul = pul; v.wr = wr; v.add = add; v.din = din; v.rd = rd;
    return v;
  endfunction

  function automatic logic [31:0] outs();
    return {3'b0, p0_gnt, p1_gnt, p0_done, p1_done, mem_wr, mem_add, mem_data_in, rdata};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    p0_req = v.r0; p0_we = v.w0; p0_addr = v.a0; p0_wdata = v.d0;
    p1_req = v.r1; p1_we = v.w1; p1_addr = v.a1; p1_wdata = v.d1;
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // four tie rounds straight out of reset: p0, p1, p0, p1
    for (int i = 0; i < 11; i++) begin
      logic [3:0] p;
      logic       w;
      logic [7:0] a, d;
      case (i % 6)
        0: begin p = 4'b1000; w = 1; a = 8'h10; d = 8'h11; end
        1: begin p = 4'b0010; w = 0; a = 8'h10; d = 8'h11; end
        2: begin p = 4'b0000; w = 0; a = 8'h10; d = 8'h11; end
        3: begin p = 4'b0100; w = 1; a = 8'h20; d = 8'h22; end
        4: begin p = 4'b0001; w = 0; a = 8'h20; d = 8'h22; end
        default: begin p = 4'b0000; w = 0; a = 8'h20; d = 8'h22; end
      endcase
      vecs[i] = mk(1, 1, 8'h10, 8'h11, 1, 1, 8'h20, 8'h22, p, w, a, d, 8'h00);
    end
    vecs[11] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 8'h20, 8'h22, 8'h00);
    // p0 write 0x03 <- 0xA5, then p1 raises a read of 0x03 during DONE
    vecs[12] = mk(1, 1, 8'h03, 8'hA5, 0, 0, 8'h00, 8'h00, 4'b1000, 1, 8'h03, 8'hA5, 8'h00);
    vecs[13] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0010, 0, 8'h03, 8'hA5, 8'h00);
    vecs[14] = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h03, 8'h00, 4'b0000, 0, 8'h03, 8'hA5, 8'h00);
    vecs[15] = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h03, 8'h00, 4'b0100, 0, 8'h03, 8'h00, 8'h00);
    vecs[16] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0001, 0, 8'h03, 8'h00, 8'hA5);
    vecs[17] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 8'h03, 8'h00, 8'hA5);
    // p0 holds a read of 0x10 for three back-to-back accesses
    for (int i = 18; i < 26; i++) begin
      logic [3:0] p;
      logic [7:0] rd;
      p  = ((i - 18) % 3 == 0) ? 4'b1000 : ((i - 18) % 3 == 1) ? 4'b0010 : 4'b0000;
      rd = (i == 18) ? 8'hA5 : 8'h11;
      vecs[i] = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, p, 0, 8'h10, 8'h00, rd);
    end
    vecs[26] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 8'h10, 8'h00, 8'h11);
    // p1 reads back what it wrote during the tie rounds
    vecs[27] = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 4'b0100, 0, 8'h20, 8'h00, 8'h11);
    vecs[28] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0001, 0, 8'h20, 8'h00, 8'h22);
    vecs[29] = mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 4'b0000, 0, 8'h20, 8'h00, 8'h22);

    // reset state
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 32'h0);
    check("reset_state", {30'b0, dut.state}, {30'b0, IDLE});
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      drive(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d", i), outs(),
            {3'b0, vecs[i].pul, vecs[i].wr, vecs[i].add, vecs[i].din, vecs[i].rd});
    end

    // reset pulled low in the middle of a p0 write
    p0_req = 1; p0_we = 1; p0_addr = 8'h55; p0_wdata = 8'h66;
    @(posedge clk);
    @(negedge clk);
    check("abort_pre_gnt", {31'b0, p0_gnt}, 32'd1);
    check("abort_pre_wr", {31'b0, mem_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_outs", outs(), 32'h0);
    check("abort_state", {30'b0, dut.state}, {30'b0, IDLE});
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("abort_nodone%0d", i), {28'b0, p0_gnt, p1_gnt, p0_done, p1_done}, 32'd0);
    end
    check("abort_nowrite", {24'b0, mem[8'h55]}, 32'h0);

    // tie after reset: pointer restarts at p0; p1 then reads p0's data
    p0_req = 1; p0_we = 1; p0_addr = 8'h55; p0_wdata = 8'h77;
    p1_req = 1; p1_we = 0; p1_addr = 8'h55; p1_wdata = 8'h00;
    @(posedge clk); @(negedge clk);
    check("tie2_gnt0", outs(), {3'b0, 4'b1000, 1'b1, 8'h55, 8'h77, 8'h00});
    p0_req = 0;
    @(posedge clk); @(negedge clk);
    check("tie2_done0", outs(), {3'b0, 4'b0010, 1'b0, 8'h55, 8'h77, 8'h00});
    @(posedge clk); @(negedge clk);
    check("tie2_idle", outs(), {3'b0, 4'b0000, 1'b0, 8'h55, 8'h77, 8'h00});
    @(posedge clk); @(negedge clk);
    check("tie2_gnt1", outs(), {3'b0, 4'b0100, 1'b0, 8'h55, 8'h00, 8'h00});
    idle_inputs();
    @(posedge clk); @(negedge clk);
    check("tie2_done1", outs(), {3'b0, 4'b0001, 1'b0, 8'h55, 8'h00, 8'h77});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
